// File: rtl/alu_pkg.sv
// Shared definitions for the alu_mdu block: operation codes, FSM states and a small op classifier.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  // True for the ops that go through the multi-cycle multiply/divide engine.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Handshake and data bus between operand-fetch, the ALU/MDU and writeback.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             busy;

  modport master (
    output in_valid, op, input_a, input_b, out_ready,
    input  in_ready, out_valid, result, result_hi, busy
  );

  modport slave (
    input  in_valid, op, input_a, input_b, out_ready,
    output in_ready, out_valid, result, result_hi, busy
  );

endinterface

// File: rtl/alu_md_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per clock over WIDTH steps.
// The hi/lo register pair holds the running product for MULU, and remainder/quotient for DIVU.
// lo/hi present the value after the current step, so they are final while done is high.
module alu_md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  logic             active;
  logic             div_mode;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // One multiply or divide step; a clear top bit of div_diff means the trial subtraction did not borrow.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? operand : {WIDTH{1'b0}})};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (div_mode) begin
      if (!div_diff[WIDTH]) begin
        hi_d = div_diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done = active && (count == LAST_STEP);
  assign lo   = lo_d;
  assign hi   = hi_d;

  // Load operands on start, then advance one step per clock until the last step completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      active   <= 1'b0;
      div_mode <= 1'b0;
      count    <= '0;
      operand  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (start) begin
      active   <= 1'b1;
      div_mode <= is_div;
      count    <= '0;
      operand  <= is_div ? b : a;
      hi_q     <= '0;
      lo_q     <= is_div ? a : b;
    end else if (active) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      count <= count + 1'b1;
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Registered ALU with single-cycle ops plus iterative MULU/DIVU, valid/ready on both sides.
// Results are held in the output register until the consumer takes them.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  alu_mdu_if.slave bus
);

  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic             accept;
  logic             start_iter;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] single_res;
  logic [SHW-1:0]   shamt;

  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign start_iter   = accept && is_iter_op(bus.op);

  alu_md_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start_iter),
    .is_div (bus.op == OP_DIVU),
    .a      (bus.input_a),
    .b      (bus.input_b),
    .done   (iter_done),
    .lo     (iter_lo),
    .hi     (iter_hi)
  );

  // Single-cycle result mux; reserved codes and the iterative ops produce zero here.
  always_comb begin
    shamt      = bus.input_b[SHW-1:0];
    single_res = '0;
    case (bus.op)
      OP_ADD:  single_res = bus.input_a + bus.input_b;
      OP_SUB:  single_res = bus.input_a - bus.input_b;
      OP_AND:  single_res = bus.input_a & bus.input_b;
      OP_OR:   single_res = bus.input_a | bus.input_b;
      OP_XOR:  single_res = bus.input_a ^ bus.input_b;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.input_a) < $signed(bus.input_b))};
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (bus.input_a < bus.input_b)};
      OP_SLL:  single_res = bus.input_a << shamt;
      OP_SRL:  single_res = bus.input_a >> shamt;
      OP_SRA:  single_res = $signed(bus.input_a) >>> shamt;
      default: single_res = '0;
    endcase
  end

  // Control FSM and output register: accept, iterate, hold under backpressure, release on consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_iter) begin
            state         <= ITER;
            bus.busy      <= 1'b1;
            bus.out_valid <= 1'b0;
          end else if (accept) begin
            bus.result    <= single_res;
            bus.result_hi <= '0;
            bus.out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
          end
        end
        ITER: begin
          if (iter_done) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.result    <= iter_lo;
            bus.result_hi <= iter_hi;
            bus.out_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;

  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_mdu_if #(.WIDTH(W)) bus ();

  alu_mdu #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.input_a   = '0;
    bus.input_b   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result got=%h exp=0", bus.result); end
    checks++; if (bus.result_hi !== 32'h0) begin failures++; $display("[TB] FAIL reset_result_hi got=%h exp=0", bus.result_hi); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_single_cycle();
    vec_t v [13];
    v = '{
      '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
      '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
      '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
      '{OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000},
      '{OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE},
      '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0},
      '{OP_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0},
      '{OP_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00},
      '{OP_SLL,  32'h00000001, 32'h00000025, 32'h00000020},
      '{OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001},
      '{OP_SRA,  32'h40000000, 32'h00000002, 32'h10000000},
      '{4'd15,   32'h00000001, 32'h00000002, 32'h00000000},
      '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000}
    };
    for (int i = 0; i < 13; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = v[i].op;
      bus.input_a  = v[i].a;
      bus.input_b  = v[i].b;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid[%0d] got=%b exp=1", i, bus.out_valid); end
      checks++; if (bus.result !== v[i].exp) begin failures++; $display("[TB] FAIL single_result[%0d] op=%0d got=%h exp=%h", i, v[i].op, bus.result, v[i].exp); end
      checks++; if (bus.result_hi !== 32'h0) begin failures++; $display("[TB] FAIL single_hi[%0d] got=%h exp=0", i, bus.result_hi); end
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_consume_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin failures++; $display("[TB] FAIL single_consume_keep got=%h exp=0", bus.result); end
  endtask

  task automatic test_mulu();
    int busy_cycles;
    int ready_cycles;
    int valid_cycles;
    busy_cycles  = 0;
    ready_cycles = 0;
    valid_cycles = 0;
    bus.in_valid = 1'b1;
    bus.op       = OP_MULU;
    bus.input_a  = 32'hFFFFFFFF;
    bus.input_b  = 32'hFFFFFFFF;
    tick();
    bus.op      = OP_ADD;
    bus.input_a = 32'h00000001;
    bus.input_b = 32'h00000001;
    for (int c = 1; c <= 32; c++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.in_ready !== 1'b0) ready_cycles++;
      if (bus.out_valid !== 1'b0) valid_cycles++;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++; if (busy_cycles !== 32) begin failures++; $display("[TB] FAIL mulu_busy_cycles got=%0d exp=32", busy_cycles); end
    checks++; if (ready_cycles !== 0) begin failures++; $display("[TB] FAIL mulu_in_ready_while_busy got=%0d exp=0", ready_cycles); end
    checks++; if (valid_cycles !== 0) begin failures++; $display("[TB] FAIL mulu_early_valid got=%0d exp=0", valid_cycles); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mulu_valid_c33 got=%b exp=1", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL mulu_busy_c33 got=%b exp=0", bus.busy); end
    checks++; if (bus.result_hi !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL mulu_hi got=%h exp=fffffffe", bus.result_hi); end
    checks++; if (bus.result !== 32'h00000001) begin failures++; $display("[TB] FAIL mulu_lo got=%h exp=00000001", bus.result); end
    tick();
  endtask

  task automatic test_divu();
    vec_t v [4];
    v = '{
      '{OP_DIVU, 32'd100,       32'd7,  32'd14},
      '{OP_DIVU, 32'd5,         32'd0,  32'hFFFFFFFF},
      '{OP_DIVU, 32'hFFFFFFFF,  32'd10, 32'h19999999},
      '{OP_MULU, 32'h00012345,  32'h00010000, 32'h23450000}
    };
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] exp_hi;
      case (i)
        0:       exp_hi = 32'd2;
        1:       exp_hi = 32'd5;
        2:       exp_hi = 32'd5;
        default: exp_hi = 32'h00000001;
      endcase
      bus.in_valid = 1'b1;
      bus.op       = v[i].op;
      bus.input_a  = v[i].a;
      bus.input_b  = v[i].b;
      tick();
      bus.in_valid = 1'b0;
      bus.input_a  = 32'h0BADF00D;
      bus.input_b  = 32'h00000003;
      for (int c = 1; c < 32; c++) tick();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL iter_valid_c32[%0d] got=%b exp=0", i, bus.out_valid); end
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL iter_valid_c33[%0d] got=%b exp=1", i, bus.out_valid); end
      checks++; if (bus.result !== v[i].exp) begin failures++; $display("[TB] FAIL iter_result[%0d] got=%h exp=%h", i, bus.result, v[i].exp); end
      checks++; if (bus.result_hi !== exp_hi) begin failures++; $display("[TB] FAIL iter_result_hi[%0d] got=%h exp=%h", i, bus.result_hi, exp_hi); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.input_a   = 32'd3;
    bus.input_b   = 32'd4;
    tick();
    bus.op = OP_SUB;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_valid[%0d] got=%b exp=1", c, bus.out_valid); end
      checks++; if (bus.result !== 32'd7) begin failures++; $display("[TB] FAIL bp_hold_result[%0d] got=%h exp=7", c, bus.result); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready[%0d] got=%b exp=0", c, bus.in_ready); end
      if (c < 2) tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_no_bubble got=%b exp=1", bus.out_valid); end
    checks++; if (bus.result !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL bp_sub_result got=%h exp=ffffffff", bus.result); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_consume_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.result !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL bp_consume_keep got=%h exp=ffffffff", bus.result); end
  endtask

  task automatic test_reset_mid_op();
    int late_valid;
    late_valid   = 0;
    bus.in_valid = 1'b1;
    bus.op       = OP_MULU;
    bus.input_a  = 32'h00001234;
    bus.input_b  = 32'h00005678;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin failures++; $display("[TB] FAIL rst_mid_result got=%h exp=0", bus.result); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_in_ready got=%b exp=1", bus.in_ready); end
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = OP_ADD;
    bus.input_a  = 32'd1;
    bus.input_b  = 32'd1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rst_add_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.result !== 32'd2) begin failures++; $display("[TB] FAIL rst_add_result got=%h exp=2", bus.result); end
    tick();
    for (int c = 0; c < 30; c++) begin
      if (bus.out_valid !== 1'b0) late_valid++;
      tick();
    end
    checks++; if (late_valid !== 0) begin failures++; $display("[TB] FAIL rst_stale_result got=%0d exp=0", late_valid); end
  endtask

  task automatic test_back_to_back();
    int low_cycles;
    low_cycles    = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.input_a   = 32'd10;
    bus.input_b   = 32'd20;
    tick();
    checks++; if (bus.result !== 32'd30) begin failures++; $display("[TB] FAIL b2b_add got=%h exp=1e", bus.result); end
    bus.op      = OP_XOR;
    bus.input_a = 32'hA5A5A5A5;
    bus.input_b = 32'hFFFF0000;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_xor_ready got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_xor_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.result !== 32'h5A5AA5A5) begin failures++; $display("[TB] FAIL b2b_xor got=%h exp=5a5aa5a5", bus.result); end
    bus.op      = OP_DIVU;
    bus.input_a = 32'd1000;
    bus.input_b = 32'd10;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_divu_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_divu_drop got=%b exp=0", bus.out_valid); end
    while (bus.in_ready !== 1'b1 && low_cycles < 40) begin
      low_cycles++;
      tick();
    end
    checks++; if (low_cycles !== 32) begin failures++; $display("[TB] FAIL b2b_ready_low got=%0d exp=32", low_cycles); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_divu_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.result !== 32'd100) begin failures++; $display("[TB] FAIL b2b_divu_q got=%h exp=64", bus.result); end
    checks++; if (bus.result_hi !== 32'd0) begin failures++; $display("[TB] FAIL b2b_divu_r got=%h exp=0", bus.result_hi); end
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_cycle();
    test_mulu();
    test_divu();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
